seq_detect_param: RTL and testbench

Parametrised serial pattern detector. Matches a runtime-loadable bit pattern of 1..MAX_LEN bits against a qualified serial stream. Supports overlapping and non-overlapping match modes and a saturating hit counter. Sits on the same serial-input path as the team's fixed-pattern detectors and replaces them; out of reset it detects 10110 with overlap.

---
 rtl/seq_detect_pkg.sv | 16 +
 rtl/seq_hit_counter.sv | 26 ++
 rtl/seq_detect_param.sv | 113 +++++++++++
 tb/tb_seq_detect_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared constants, width helper and mode enum for the serial pattern detector
package seq_detect_pkg;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam logic [7:0] DEF_RESET_PATTERN = 8'b0001_0110;
  localparam int         DEF_RESET_LEN     = 5;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

endpackage

// File: rtl/seq_hit_counter.sv
// rtl/seq_hit_counter.sv - saturating hit counter with synchronous clear (clear beats increment)
module seq_hit_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-loadable serial pattern detector, overlap/non-overlap modes
// Hit counter built only when SEQ_DET_HIT_CNT_EN is defined; otherwise hit_count is tied to 0.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN       = 8,
  parameter int                 CNT_W         = 16,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(DEF_RESET_PATTERN),
  parameter int                 RESET_LEN     = DEF_RESET_LEN,
  localparam int                LEN_W         = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_in,
  input  logic               data_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               data_out,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   hit_count
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  mode_e              ovl_q, ovl_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic               data_out_q, cfg_err_q;

  logic [MAX_LEN-1:0] win, mask;
  logic               cfg_ok, fill_enough, fill_sat, match;

  // Window holds the newest MAX_LEN bits including the one on the wire now.
  assign win         = {hist_q, data_in};
  assign cfg_ok      = cfg_load && (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
  assign fill_enough = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign fill_sat    = (fill_q == LEN_W'(MAX_LEN));

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // An accepted load swallows the coincident bit, so no match can fire on it.
  assign match = data_valid && !cfg_ok && fill_enough && ((win & mask) == (pat_q & mask));

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_ok) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = mode_e'(cfg_overlap);
      hist_d = '0;
      fill_d = '0;
    end else if (data_valid) begin
      hist_d = win[MAX_LEN-2:0];
      if (match && (ovl_q == NON_OVERLAP)) begin
        fill_d = '0;
      end else if (!fill_sat) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= RESET_PATTERN;
      len_q      <= LEN_W'(RESET_LEN);
      ovl_q      <= OVERLAP;
      hist_q     <= '0;
      fill_q     <= '0;
      data_out_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      data_out_q <= match;
      cfg_err_q  <= cfg_load && !cfg_ok;
    end
  end

  assign data_out = data_out_q;
  assign cfg_err  = cfg_err_q;

`ifdef SEQ_DET_HIT_CNT_EN
  seq_hit_counter #(
    .CNT_W(CNT_W)
  ) u_hit_counter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (cnt_clr || cfg_ok),
    .inc_i  (match),
    .count_o(hit_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign hit_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - table-driven bench for seq_detect_param plus reset and saturation sequences
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b0, data_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic        data_out, cfg_err, data_out2, cfg_err2;
  logic [15:0] hit_count;
  logic [1:0]  hit_count2;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_DET_HIT_CNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .data_out(data_out), .cfg_err(cfg_err), .hit_count(hit_count)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .data_out(data_out2), .cfg_err(cfg_err2), .hit_count(hit_count2)
  );

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       clr;
    logic       vld;
    logic       din;
    logic       eo;
    logic       ee;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                              input logic ovl, input logic clr, input logic vld, input logic din,
                              input logic eo, input logic ee, input int ec);
    vec_t v;
    v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.clr = clr;
    v.vld = vld; v.din = din; v.eo = eo; v.ee = ee; v.ec = ec;
    return v;
  endfunction

  task automatic add_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                         input logic vld, input logic din, input logic ee, input int ec);
    tbl.push_back(mk(1'b1, pat, len, ovl, 1'b0, vld, din, 1'b0, ee, ec));
  endtask

  // n valid bits, first bit in din[n-1]; ec accumulates from the expected pulses.
  task automatic add_stream(input logic [15:0] din, input logic [15:0] eo, input int n, input int base);
    int c = base;
    for (int i = n - 1; i >= 0; i--) begin
      if (eo[i]) c++;
      tbl.push_back(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, din[i], eo[i], 1'b0, c));
    end
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cfg_load = v.ld; cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ovl;
    cnt_clr = v.clr; data_valid = v.vld; data_in = v.din;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t bitv(input logic din);
    return mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, din, 1'b0, 1'b0, 0);
  endfunction

  initial begin
    // Default pattern, overlapping
    add_stream(16'b1011_0110, 16'b0000_1001, 8, 0);
    // Same pattern, non-overlapping; the bit on the load cycle is discarded
    add_cfg(8'b0001_0110, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add_stream(16'b1011_0110, 16'b0000_1000, 8, 0);
    // 111, non-overlap then overlap (upper pattern bits must be ignored)
    add_cfg(8'b0000_0111, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add_stream(16'b11_1111, 16'b00_1001, 6, 0);
    add_cfg(8'b1010_0111, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add_stream(16'b11_1111, 16'b00_1111, 6, 0);
    // Default pattern with two idle cycles between valid bits
    add_cfg(8'b0001_0110, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 4; i >= 0; i--) begin
      logic [4:0] p;
      p = 5'b10110;
      tbl.push_back(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, p[i], (i == 0), 1'b0, (i == 0) ? 1 : 0));
      if (i != 0) begin
        tbl.push_back(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        tbl.push_back(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      end
    end
    // Rejected loads (len 0, len MAX_LEN+1): bits still processed, config kept
    add_cfg(8'hFF, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    add_cfg(8'hFF, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    add_stream(16'b110, 16'b001, 3, 1);
    // Full-length pattern
    add_cfg(8'b1100_1010, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add_stream(16'b1100_1010, 16'b0000_0001, 8, 0);
    // Length 1 pattern "0", then clear coincident with a match
    add_cfg(8'b1111_1110, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add_stream(16'b100, 16'b011, 3, 0);
    tbl.push_back(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0));
    tbl.push_back(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1));

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset data_out", 0, data_out, 0);
    check("reset cfg_err", 0, cfg_err, 0);
    check("reset hit_count", 0, hit_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      check("data_out", i, data_out, tbl[i].eo);
      check("cfg_err", i, cfg_err, tbl[i].ee);
      check("hit_count", i, hit_count, HIT_EN ? tbl[i].ec : 0);
    end

    // CNT_W=2 saturation on a length-1 pattern "1"
    drive(mk(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    check("sat cleared", 0, hit_count2, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(bitv(1'b1));
      check("sat data_out", k, data_out2, 1);
      check("sat hit_count", k, hit_count2, HIT_EN ? ((k > 3) ? 3 : k) : 0);
    end
    check("wide hit_count", 5, hit_count, HIT_EN ? 5 : 0);
    drive(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    check("clr vs match data_out", 0, data_out2, 1);
    check("clr vs match hit_count", 0, hit_count2, 0);
    drive(bitv(1'b1));
    check("count after clr", 0, hit_count, HIT_EN ? 1 : 0);

    // Asynchronous reset mid-stream: config, history and outputs all revert
    drive(bitv(1'b1));
    drive(bitv(1'b0));
    drive(bitv(1'b1));
    check("pre-reset data_out", 0, data_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset data_out", 0, data_out, 0);
    check("async reset hit_count", 0, hit_count, 0);
    data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(bitv(1'b1));
    check("post-reset bit1", 1, data_out, 0);
    drive(bitv(1'b0));
    check("post-reset bit2", 2, data_out, 0);
    drive(bitv(1'b1));
    check("post-reset bit3", 3, data_out, 0);
    drive(bitv(1'b1));
    check("post-reset bit4", 4, data_out, 0);
    drive(bitv(1'b0));
    check("post-reset bit5", 5, data_out, 1);
    check("post-reset hit_count", 5, hit_count, HIT_EN ? 1 : 0);
    drive(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    check("pulse width", 6, data_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
